// File: rtl/bpu_btb_predictor_pkg.sv
// bpu_btb_predictor_pkg: shared constants, counter encoding and resolved-branch bus layout
package bpu_btb_predictor_pkg;
    localparam int BRESULT_WD = 68;
    localparam int BPU_ENTRIES = 16;
    localparam int UPD_PC_LSB = 36;
    localparam int UPD_COUNT_LSB = 34;
    localparam int UPD_IS_BRANCH = 33;
    localparam int UPD_TAKEN = 32;
    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  count;
        logic        is_branch;
        logic        taken;
        logic [31:0] target;
    } bresult_t;
endpackage

// File: rtl/bpu_btb_predictor_if.sv
// bpu_btb_predictor_if: fetch lookup, prediction result and EXE training bus
interface bpu_btb_predictor_if;
    logic                                         lk_valid;
    logic [31:0]                                  lk_pc;
    logic                                         lk_hold;
    logic                                         flush;
    logic                                         bpu_valid;
    logic                                         bpu_taken;
    logic [31:0]                                  bpu_target;
    logic [1:0]                                   bpu_count;
    logic                                         upd_valid;
    logic [bpu_btb_predictor_pkg::BRESULT_WD-1:0] upd_bus;
    modport master (
        output lk_valid, lk_pc, lk_hold, flush, upd_valid, upd_bus,
        input  bpu_valid, bpu_taken, bpu_target, bpu_count
    );
    modport slave (
        input  lk_valid, lk_pc, lk_hold, flush, upd_valid, upd_bus,
        output bpu_valid, bpu_taken, bpu_target, bpu_count
    );
endinterface

// File: rtl/bpu_sat_ctr.sv
// bpu_sat_ctr: 2-bit saturating counter next state
module bpu_sat_ctr
    import bpu_btb_predictor_pkg::*;
(
    input  ctr_e ctr,
    input  logic taken,
    output ctr_e nxt
);
    always_comb
        nxt = taken ? ((ctr == CTR_ST) ? CTR_ST : ctr_e'(ctr + 2'd1))
                    : ((ctr == CTR_SNT) ? CTR_SNT : ctr_e'(ctr - 2'd1));
endmodule

// File: rtl/bpu_btb_predictor.sv
// bpu_btb_predictor: direct-mapped BTB with 2-bit counters, one-cycle registered lookup
module bpu_btb_predictor
    import bpu_btb_predictor_pkg::*;
#(
    parameter int ENTRIES = BPU_ENTRIES,
    parameter int IDX_W = $clog2(ENTRIES)
) (
    input logic                 clk,
    input logic                 reset,
    bpu_btb_predictor_if.slave  bus
);
    localparam int TAG_W = 30 - IDX_W;
    logic [ENTRIES-1:0] vld;
    logic [TAG_W-1:0]   tag [ENTRIES];
    logic [29:0]        tgt [ENTRIES];
    ctr_e               ctr [ENTRIES];
    bresult_t           u;
    logic [IDX_W-1:0]   lk_idx, u_idx;
    logic [TAG_W-1:0]   lk_tag, u_tag;
    logic               lk_hit, u_hit, h;
    ctr_e               ctr_nxt;
    logic               unused;
    assign u      = bus.upd_bus;
    assign lk_idx = bus.lk_pc[IDX_W+1:2];
    assign lk_tag = bus.lk_pc[31:IDX_W+2];
    assign u_idx  = u.pc[IDX_W+1:2];
    assign u_tag  = u.pc[31:IDX_W+2];
    assign lk_hit = vld[lk_idx] & (tag[lk_idx] == lk_tag);
    assign u_hit  = vld[u_idx] & (tag[u_idx] == u_tag);
    assign h      = bus.lk_valid & lk_hit;
    // the count carried on the bus is only informational; training uses the stored counter
    assign unused = ^{bus.lk_pc[1:0], u.count, u.pc[1:0], u.target[1:0]};
    bpu_sat_ctr u_sat (
        .ctr   (ctr[u_idx]),
        .taken (u.taken),
        .nxt   (ctr_nxt)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_SNT;
        end else if (bus.upd_valid) begin
            if (u.is_branch && u_hit) ctr[u_idx] <= ctr_nxt;
            else if (u.is_branch && u.taken) begin
                vld[u_idx] <= 1'b1;
                ctr[u_idx] <= CTR_WT;
            end else if (!u.is_branch && u_hit) vld[u_idx] <= 1'b0;
        end
    end
    // tag/target need no reset: they are qualified by vld
    always_ff @(posedge clk) begin
        if (!reset && bus.upd_valid && u.is_branch && u.taken) begin
            tgt[u_idx] <= u.target[31:2];
            if (!u_hit) tag[u_idx] <= u_tag;
        end
    end
    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            bus.bpu_valid  <= 1'b0;
            bus.bpu_taken  <= 1'b0;
            bus.bpu_target <= '0;
            bus.bpu_count  <= '0;
        end else if (!bus.lk_hold) begin
            bus.bpu_valid  <= h;
            bus.bpu_taken  <= h & ctr[lk_idx][1];
            bus.bpu_target <= h ? {tgt[lk_idx], 2'b00} : 32'h0;
            bus.bpu_count  <= h ? 2'(ctr[lk_idx]) : 2'b00;
        end
    end
endmodule
